// File: rtl/m41_pkg.sv
// Shared select-code definitions for the m41 source-select mux.
package m41_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

endpackage

// File: rtl/m41_mux4_comb.sv
// mux4_comb: WIDTH-bit 4:1 combinational mux, each bit muxed by the same select.
// Latency: zero cycles; no backpressure (pure datapath, no handshake).
module mux4_comb
    import m41_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] y
);

    // An unknown select falls to the default so simulation shows X on y.
    always_comb begin
        y = '0;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/m41.sv
// m41: 4:1 source-select mux with combinational out plus registered out_q/sel_q.
// Latency: out 0 cycles, out_q/sel_q 1 cycle when en=1; no backpressure (no handshake).
module m41
    import m41_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q
);

    logic [SEL_W-1:0] sel;

    assign sel = {s1, s0};

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y   (out)
    );

    // Reset wins over enable; sel_q records the select that produced out_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= RESET_VAL;
            sel_q <= SEL_A;
        end else if (en) begin
            out_q <= out;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_m41.sv
`timescale 1ns/100ps
// Bench for m41 (WIDTH=8): scoreboard queue of expected out_q/sel_q per edge,
// popped by an independent monitor; combinational out checked right after each input change.
module tb_m41;

    localparam int             W  = 8;
    localparam logic [W-1:0]   RV = 8'hA5;

    typedef struct packed {
        logic [W-1:0] q;
        logic [1:0]   sel;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         s1;
    logic         s0;
    logic [W-1:0] din [4];
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic [1:0]   sel_q;

    int checks   = 0;
    int failures = 0;

    exp_t         sbq [$];
    exp_t         mon_e;
    logic [W-1:0] m_q;
    logic [1:0]   m_sel;
    bit           m_ok = 1'b0;

    m41 #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (din[0]),
        .b     (din[1]),
        .c     (din[2]),
        .d     (din[3]),
        .s1    (s1),
        .s0    (s0),
        .out   (out),
        .out_q (out_q),
        .sel_q (sel_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the next rising edge must leave in out_q/sel_q.
    task automatic model_edge(input logic r, input logic e, input logic [1:0] s);
        exp_t x;
        if (r) begin
            m_q   = RV;
            m_sel = 2'b00;
            m_ok  = 1'b1;
        end else if (e && m_ok) begin
            m_q   = din[s];
            m_sel = s;
        end
        if (m_ok) begin
            x.q   = m_q;
            x.sel = m_sel;
            sbq.push_back(x);
        end
    endtask

    // Called just after a falling edge: drive, check comb path and pre-edge hold, queue expectation.
    task automatic apply(input logic r, input logic e,
                         input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [W-1:0] vd,
                         input logic [1:0] s);
        rst = r;
        en  = e;
        din[0] = va;
        din[1] = vb;
        din[2] = vc;
        din[3] = vd;
        {s1, s0} = s;
        #1;
        chk("out_comb", out, din[s]);
        if (m_ok) begin
            chk("out_q_pre_edge", out_q, m_q);
            chk("sel_q_pre_edge", {6'b0, sel_q}, {6'b0, m_sel});
        end
        model_edge(r, e, s);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("out_q", out_q, mon_e.q);
                chk("sel_q", {6'b0, sel_q}, {6'b0, mon_e.sel});
            end
        end
    end

    initial begin
        logic [1:0]   s;
        logic [W-1:0] r0, r1, r2, r3;
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        {s1, s0} = 2'b00;
        @(negedge clk);

        // Reset state
        apply(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        apply(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);

        // Static sweep with no clock edge in between
        rst = 1'b0;
        en  = 1'b0;
        din[0] = 8'h00; din[1] = 8'h01; din[2] = 8'h00; din[3] = 8'h01;
        model_edge(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            {s1, s0} = s;
            #1;
            chk("static_sweep", out, (i % 2 == 1) ? 8'h01 : 8'h00);
        end
        @(negedge clk);

        // Toggling inputs at binary rates, offset from both clock edges
        #2.5;
        for (int k = 0; k < 100; k++) begin
            din[3] = {W{k[0]}};
            din[2] = {W{k[1]}};
            din[1] = {W{k[2]}};
            din[0] = {W{k[3]}};
            s0 = k[4];
            s1 = k[5];
            #1;
            chk("toggle_out", out, {W{k[{k[5], k[4]} == 2'b00 ? 3 : ({k[5], k[4]} == 2'b01 ? 2 :
                                        ({k[5], k[4]} == 2'b10 ? 1 : 0))]}});
            if (k % 2 == 0) model_edge(1'b0, 1'b0, {s1, s0});
            #4;
        end
        @(negedge clk);

        // Registered path, then hold with every input changing
        apply(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h00, 2'b10);
        for (int i = 0; i < 4; i++)
            apply(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'(i));

        // Reset together with enable, then deassert between edges
        apply(1'b1, 1'b1, 8'h5A, 8'h3C, 8'hC3, 8'h96, 2'b11);
        apply(1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 2'b01);

        // Wide select sweep with one-cycle lag on out_q
        for (int i = 0; i < 4; i++)
            apply(1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 2'(i));

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            apply(($urandom_range(0, 15) == 0), 1'($urandom), r0, r1, r2, r3, 2'($urandom));
        end

        @(posedge clk);
        #2;
        chk("sb_drain", 8'(sbq.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
